// File: rtl/sram_ctrl.sv
// Single-port async SRAM controller: one read or write per start handshake, fixed-length access phase.
// Optional write read-back verification is compiled in with `define SRAM_CTRL_VERIFY_EN.
module sram_ctrl #(
   parameter int WAIT_CYCLES = 2
) (
   input  logic        CLOCK_50,
   input  logic        reset,
   input  logic        start,
   input  logic        rw,
   input  logic [19:0] address,
   input  logic [15:0] dataIn,
   output logic [15:0] dataOut,
   output logic        done,
   output logic        busy,
   output logic        err,
   output logic [19:0] SRAM_ADDR,
   inout  wire  [15:0] SRAM_DQ,
   output logic        SRAM_CE_N,
   output logic        SRAM_OE_N,
   output logic        SRAM_WE_N,
   output logic        SRAM_UB_N,
   output logic        SRAM_LB_N,
   output logic [2:0]  state
);

   // Handshake: the requester raises start and holds it until it sees the one-cycle done
   // pulse; a new transaction is only accepted after start has been seen low in RELEASE.
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ACCESS  = 3'd1,
      TURN    = 3'd2,
      VERIFY  = 3'd3,
      DONE    = 3'd4,
      RELEASE = 3'd5
   } state_t;

   localparam int W_EFF = (WAIT_CYCLES < 1) ? 1 : ((WAIT_CYCLES > 15) ? 15 : WAIT_CYCLES);
   localparam logic [3:0] WAIT_LD = W_EFF[3:0];

   state_t      st;
   logic        rw_q;
   logic [15:0] data_q;
   logic [3:0]  cnt;
   logic        dq_oe;

   assign state   = st;
   assign SRAM_DQ = dq_oe ? data_q : 16'hzzzz;

`ifdef SRAM_CTRL_VERIFY_EN
   logic err_q;
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         st        <= IDLE;
         rw_q      <= 1'b0;
         data_q    <= 16'h0000;
         cnt       <= 4'd0;
         dq_oe     <= 1'b0;
         dataOut   <= 16'h0000;
         done      <= 1'b0;
         busy      <= 1'b0;
         SRAM_ADDR <= 20'h00000;
         SRAM_CE_N <= 1'b1;
         SRAM_OE_N <= 1'b1;
         SRAM_WE_N <= 1'b1;
         SRAM_UB_N <= 1'b1;
         SRAM_LB_N <= 1'b1;
`ifdef SRAM_CTRL_VERIFY_EN
         err_q     <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (st)
            IDLE: begin
               if (start) begin
                  rw_q      <= rw;
                  data_q    <= dataIn;
                  SRAM_ADDR <= address;
                  cnt       <= WAIT_LD;
                  busy      <= 1'b1;
                  SRAM_CE_N <= 1'b0;
                  SRAM_UB_N <= 1'b0;
                  SRAM_LB_N <= 1'b0;
                  SRAM_WE_N <= ~rw;
                  SRAM_OE_N <= rw;
                  dq_oe     <= rw;
                  st        <= ACCESS;
               end
            end
            ACCESS: begin
               if (cnt == 4'd1) begin
                  if (!rw_q) dataOut <= SRAM_DQ;
                  SRAM_CE_N <= 1'b1;
                  SRAM_OE_N <= 1'b1;
                  SRAM_WE_N <= 1'b1;
                  SRAM_UB_N <= 1'b1;
                  SRAM_LB_N <= 1'b1;
                  dq_oe     <= 1'b0;
`ifdef SRAM_CTRL_VERIFY_EN
                  if (rw_q) begin
                     st <= TURN;
                  end else begin
                     st   <= DONE;
                     done <= 1'b1;
                  end
`else
                  st   <= DONE;
                  done <= 1'b1;
`endif
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
`ifdef SRAM_CTRL_VERIFY_EN
            // One dead clock with the bus released before reading the word back.
            TURN: begin
               cnt       <= WAIT_LD;
               SRAM_CE_N <= 1'b0;
               SRAM_OE_N <= 1'b0;
               SRAM_UB_N <= 1'b0;
               SRAM_LB_N <= 1'b0;
               st        <= VERIFY;
            end
            VERIFY: begin
               if (cnt == 4'd1) begin
                  if (SRAM_DQ != data_q) err_q <= 1'b1;
                  SRAM_CE_N <= 1'b1;
                  SRAM_OE_N <= 1'b1;
                  SRAM_UB_N <= 1'b1;
                  SRAM_LB_N <= 1'b1;
                  st        <= DONE;
                  done      <= 1'b1;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
`endif
            DONE: begin
               st <= RELEASE;
            end
            RELEASE: begin
               if (!start) begin
                  st   <= IDLE;
                  busy <= 1'b0;
               end
            end
            default: begin
               st   <= IDLE;
               busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl with a behavioural SRAM and a done-driven scoreboard.
// Define SRAM_CTRL_VERIFY_EN for both files to exercise read-back verification.
module tb_sram_ctrl;

   localparam int W = 2;
`ifdef SRAM_CTRL_VERIFY_EN
   localparam int LAT_WR = 2 * W + 2;
   localparam int OE_WR  = W;
`else
   localparam int LAT_WR = W + 1;
   localparam int OE_WR  = 0;
`endif
   localparam int LAT_RD = W + 1;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        rw = 1'b0;
   logic [19:0] address = 20'h0;
   logic [15:0] dataIn = 16'h0;
   logic [15:0] dataOut;
   logic        done, busy, err;
   logic [19:0] sram_addr;
   wire  [15:0] sram_dq;
   logic        ce_n, oe_n, we_n, ub_n, lb_n;
   logic [2:0]  state;

   sram_ctrl #(.WAIT_CYCLES(W)) dut (
      .CLOCK_50(clk), .reset(reset), .start(start), .rw(rw), .address(address),
      .dataIn(dataIn), .dataOut(dataOut), .done(done), .busy(busy), .err(err),
      .SRAM_ADDR(sram_addr), .SRAM_DQ(sram_dq), .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n),
      .SRAM_WE_N(we_n), .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .state(state)
   );

   // clock / reset
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // SRAM model: 256 words, optional bit-0 corruption on writes of 16'h00FF
   logic [15:0] mem [0:255];
   logic        corrupt_en = 1'b0;
   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
      mem[1] = 16'h1234;
   end
   assign sram_dq = (!ce_n && !oe_n && we_n) ? mem[sram_addr[7:0]] : 16'hzzzz;
   always @(posedge clk)
      if (!ce_n && !we_n)
         mem[sram_addr[7:0]] <= (corrupt_en && sram_dq == 16'h00FF) ? (sram_dq ^ 16'h0001) : sram_dq;

   // scoreboard
   typedef struct {
      logic        rw;
      logic [19:0] addr;
      logic [15:0] wdata;
      logic [15:0] rdata;
      logic        err;
      int          cyc;
   } exp_t;
   exp_t exp_q[$];

   int n_vec = 0;
   int n_err = 0;
   int n_issued = 0;
   int n_done = 0;
   logic [15:0] last_rd = 16'h0000;
   logic        exp_err = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      n_vec++;
      if (act !== want) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cyc);
      end
   endtask

   // monitor
   int we_low = 0;
   int oe_low = 0;
   always @(negedge clk) begin
      if (!busy) begin
         we_low = 0;
         oe_low = 0;
      end
      if (!we_n) we_low++;
      if (!oe_n) oe_low++;
      if (!oe_n && !we_n) check("oe_we_overlap", 32'd1, 32'd0);
      if (!we_n && exp_q.size() > 0) begin
         check("wr_dq", {16'h0, sram_dq}, {16'h0, exp_q[0].wdata});
         check("wr_addr", {12'h0, sram_addr}, {12'h0, exp_q[0].addr});
      end
      if (!oe_n && exp_q.size() > 0)
         check("rd_addr", {12'h0, sram_addr}, {12'h0, exp_q[0].addr});
      if (done) begin
         n_done++;
         if (exp_q.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("done_cycle", cyc, e.cyc);
            check("dataOut", {16'h0, dataOut}, {16'h0, e.rdata});
            check("err", {31'h0, err}, {31'h0, e.err});
            check("we_low_cycles", we_low, e.rw ? W : 0);
            check("oe_low_cycles", oe_low, e.rw ? OE_WR : W);
         end
      end
   end

   // driver
   task automatic run_txn(input logic r_w, input logic [19:0] a, input logic [15:0] d,
                          input logic [15:0] exp_rd, input int hold, input bit drop_early);
      exp_t e;
      int k;
      @(negedge clk);
      start   = 1'b1;
      rw      = r_w;
      address = a;
      dataIn  = d;
      if (!r_w) last_rd = exp_rd;
      e.rw    = r_w;
      e.addr  = a;
      e.wdata = d;
      e.rdata = last_rd;
      e.err   = exp_err;
      e.cyc   = cyc + (r_w ? LAT_WR : LAT_RD);
      exp_q.push_back(e);
      n_issued++;
      @(negedge clk);
      address = ~a;
      dataIn  = ~d;
      rw      = ~r_w;
      if (drop_early) start = 1'b0;
      k = 0;
      while (!done && k < 60) begin
         @(negedge clk);
         k++;
      end
      check("done_seen", {31'h0, done}, 32'd1);
      if (hold > 0) begin
         for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("held_busy", {31'h0, busy}, 32'd1);
            check("held_no_access", {30'h0, we_n, oe_n}, 32'd3);
         end
         start = 1'b0;
      end else begin
         start = 1'b0;
         @(negedge clk);
         check("release_busy", {31'h0, busy}, 32'd1);
      end
      @(negedge clk);
      check("idle_busy", {31'h0, busy}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_done", {31'h0, done}, 32'd0);
      check("rst_busy", {31'h0, busy}, 32'd0);
      check("rst_err", {31'h0, err}, 32'd0);
      check("rst_dataOut", {16'h0, dataOut}, 32'd0);
      check("rst_addr", {12'h0, sram_addr}, 32'd0);
      check("rst_ctrl_n", {27'h0, ce_n, oe_n, we_n, ub_n, lb_n}, 32'h1F);
      check("rst_state", {29'h0, state}, 32'd0);

      run_txn(1'b1, 20'd0, 16'h00A5, 16'h0, 0, 1'b0);
      check("mem0_after_write", {16'h0, mem[0]}, 32'h00A5);
      run_txn(1'b0, 20'd1, 16'h0, 16'h1234, 0, 1'b0);
      run_txn(1'b0, 20'd0, 16'h0, 16'h00A5, 0, 1'b0);
      // back-to-back write then read of address 1
      run_txn(1'b1, 20'd1, 16'h5A5A, 16'h0, 0, 1'b0);
      run_txn(1'b0, 20'd1, 16'h0, 16'h5A5A, 0, 1'b0);
      // start held 10 clocks beyond done
      run_txn(1'b1, 20'd2, 16'hBEEF, 16'h0, 10, 1'b0);
      // start dropped mid-transaction
      run_txn(1'b0, 20'd2, 16'h0, 16'hBEEF, 0, 1'b1);
      run_txn(1'b1, 20'hFFFFF, 16'hFFFF, 16'h0, 0, 1'b0);
      run_txn(1'b0, 20'hFFFFF, 16'h0, 16'hFFFF, 0, 1'b0);

      // reset on the first ACCESS clock of a write
      @(negedge clk);
      start = 1'b1; rw = 1'b1; address = 20'h10; dataIn = 16'hDEAD;
      @(negedge clk);
      check("pre_rst_we_n", {31'h0, we_n}, 32'd0);
      reset = 1'b1;
      start = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      last_rd = 16'h0000;
      check("midrst_ctrl_n", {27'h0, ce_n, oe_n, we_n, ub_n, lb_n}, 32'h1F);
      check("midrst_busy", {31'h0, busy}, 32'd0);
      check("midrst_state", {29'h0, state}, 32'd0);
      check("midrst_done", {31'h0, done}, 32'd0);
      check("midrst_dataOut", {16'h0, dataOut}, 32'd0);
      repeat (4) begin
         @(negedge clk);
         check("midrst_no_done", {31'h0, done}, 32'd0);
      end
      run_txn(1'b0, 20'd2, 16'h0, 16'hBEEF, 0, 1'b0);

`ifdef SRAM_CTRL_VERIFY_EN
      corrupt_en = 1'b1;
      run_txn(1'b1, 20'd3, 16'h0055, 16'h0, 0, 1'b0);
      exp_err = 1'b1;
      run_txn(1'b1, 20'd3, 16'h00FF, 16'h0, 0, 1'b0);
      corrupt_en = 1'b0;
      run_txn(1'b0, 20'd3, 16'h0, 16'h00FE, 0, 1'b0);
`endif

      repeat (3) @(negedge clk);
      check("queue_empty", exp_q.size(), 32'd0);
      check("done_count", n_done, n_issued);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2, access-phase length in clocks (legal 1..15).
REQ-002 SHALL have port CLOCK_50  in  1  sole clock, all logic on rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port start  in  1  request; held high by requester until done seen.
REQ-005 SHALL have port rw  in  1  1=write, 0=read.
REQ-006 SHALL have port address  in  20  word address.
REQ-007 SHALL have port dataIn  in  16  write data.
REQ-008 SHALL have port dataOut  out  16  read data, registered.
REQ-009 SHALL have port done  out  1  one-cycle completion pulse.
REQ-010 SHALL have port busy  out  1  high in any state other than IDLE.
REQ-011 SHALL have port err  out  1  sticky read-back mismatch flag.
REQ-012 SHALL have port SRAM_ADDR  out  20  registered SRAM address.
REQ-013 SHALL have port SRAM_DQ  inout  16  SRAM data bus.
REQ-014 SHALL have ports SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N  out  1 each  active-low SRAM controls, registered.

Function
REQ-015 SHALL implement states IDLE, ACCESS, TURN, VERIFY, DONE, RELEASE.
REQ-016 IDLE: on start=1, SHALL latch address, rw, dataIn and move to ACCESS; otherwise stay.
REQ-017 ACCESS SHALL last exactly WAIT_CYCLES clocks, counted by a 4-bit down-counter loaded on entry.
REQ-018 ACCESS write: CE_N=0, WE_N=0, OE_N=1, UB_N=LB_N=0, SRAM_DQ driven with latched data.
REQ-019 ACCESS read: CE_N=0, OE_N=0, WE_N=1, UB_N=LB_N=0, SRAM_DQ high-Z; dataOut SHALL capture SRAM_DQ on the last ACCESS clock.
REQ-020 After ACCESS SHALL go to DONE, or to TURN for a write when the verify feature is compiled in.
REQ-021 DONE SHALL last one clock with done=1; all SRAM controls deasserted (1), DQ high-Z; then RELEASE.
REQ-022 RELEASE SHALL wait for start=0 and then return to IDLE; start held high never starts a second transaction.
REQ-023 Latency: done SHALL be high WAIT_CYCLES+1 clocks after the edge at which IDLE sampled start (write without verify, or read).
REQ-024 Changes on start, rw, address, dataIn after latching SHALL be ignored until IDLE.
REQ-025 start dropping mid-transaction SHALL NOT abort; done still pulses, then RELEASE exits next clock.
REQ-026 SRAM_DQ SHALL be driven only in write ACCESS; never driven in the same clock as OE_N=0.
REQ-027 WAIT_CYCLES values outside 1..15 SHALL be clamped to 1 or 15.
REQ-028 dataOut SHALL hold its value until the next read capture.

Reset
REQ-029 On reset=1 at a clock edge, from any state, SHALL enter IDLE.
REQ-030 Reset values: done=0, busy=0, err=0, dataOut=0, SRAM_ADDR=0, all SRAM_*_N=1, SRAM_DQ high-Z.
REQ-031 Reset mid-ACCESS SHALL terminate the access in that clock with no done pulse.

Configuration
REQ-032 Macro SRAM_CTRL_VERIFY_EN defined: after a write ACCESS, one TURN clock (controls deasserted), then VERIFY as a read ACCESS of WAIT_CYCLES clocks; mismatch with latched data SHALL set err=1 (cleared only by reset); write latency becomes 2*WAIT_CYCLES+2.
REQ-033 Macro SRAM_CTRL_VERIFY_EN undefined: TURN and VERIFY absent, err tied 0, write latency WAIT_CYCLES+1.

Verification
REQ-034 Write: WAIT_CYCLES=2, start=1, rw=1, address=0, dataIn=16'h00A5 -> WE_N low 2 clocks, SRAM_ADDR=0, DQ=16'h00A5, done pulse 3 clocks after start sampled.
REQ-035 Read: SRAM model holds 16'h1234 at 20'd1, start=1, rw=0, address=1 -> OE_N low 2 clocks, DQ never driven, dataOut=16'h1234 with done.
REQ-036 Back-to-back: requester drops start on done, raises it next clock for address 1 -> exactly two transactions, RELEASE exits on the clock start=0.
REQ-037 Held start: start stays 1 for 10 clocks after done -> no second access, busy=1 until start=0.
REQ-038 Reset mid-ACCESS: reset=1 on first ACCESS clock -> next clock all SRAM_*_N=1, DQ high-Z, no done pulse, state IDLE.
REQ-039 With SRAM_CTRL_VERIFY_EN, SRAM model corrupts bit 0 on write of 16'h00FF -> err=1 and done pulse 6 clocks after start sampled (WAIT_CYCLES=2).
